// File: rtl/message_stream_arbiter_pkg.sv
// Shared types and helpers for the message stream arbiter: FSM state encoding
// and modular index arithmetic for stream selection.
package message_stream_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } state_t;

    // (a + b) mod n, valid while a < n and b <= n
    function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/message_stream_arbiter_if.sv
// Stream-side and output-side signals of the message stream arbiter.
// master: the arbiter; slave: the buffers and downstream consumer.
interface message_stream_arbiter_if #(
    parameter int unsigned N_STREAMS = 2,
    parameter int unsigned WIDTH     = 32
);
    logic [WIDTH*N_STREAMS-1:0] in_data;
    logic [N_STREAMS-1:0]       in_empty;
    logic [N_STREAMS-1:0]       in_read;
    logic [WIDTH-1:0]           out_data;
    logic                       out_nd;
    logic                       error;

    modport master (
        input  in_data, in_empty,
        output in_read, out_data, out_nd, error
    );

    modport slave (
        output in_data, in_empty,
        input  in_read, out_data, out_nd, error
    );
endinterface

// File: rtl/message_stream_arbiter_round_robin_select.sv
// Combinational rotating-priority picker: first asserted request at or after
// ptr_i, wrapping at N (which need not be a power of two).
module round_robin_select
    import message_stream_arbiter_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned LOG_N = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [LOG_N-1:0] ptr_i,
    output logic [LOG_N-1:0] grant_o,
    output logic             any_valid_o
);
    always_comb begin
        int unsigned idx;
        grant_o     = '0;
        any_valid_o = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = wrap_add(32'(ptr_i), k, N);
            if (!any_valid_o && req_i[idx[LOG_N-1:0]]) begin
                any_valid_o = 1'b1;
                grant_o     = idx[LOG_N-1:0];
            end
        end
    end
endmodule

// File: rtl/message_stream_arbiter.sv
// Packet-granular round-robin arbiter from N FWFT stream buffers onto one output.
// Define MESSAGE_STREAM_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins selection.
module message_stream_arbiter
    import message_stream_arbiter_pkg::*;
#(
    parameter int unsigned N_STREAMS             = 2,
    parameter int unsigned LOG_N_STREAMS         = 1,
    parameter int unsigned WIDTH                 = 32,
    parameter int unsigned MAX_PACKET_LENGTH     = 16,
    parameter int unsigned LOG_MAX_PACKET_LENGTH = 5
) (
    input logic                     clk,
    input logic                     rst_n,
    message_stream_arbiter_if.master bus
);
    state_t                           state_q;
    logic [LOG_N_STREAMS-1:0]         sel_q;
    logic [LOG_MAX_PACKET_LENGTH-1:0] count_q;
    logic [WIDTH-1:0]                 out_data_q;
    logic                             out_nd_q;
    logic                             error_q;

    logic [LOG_N_STREAMS-1:0]         start_ptr;
    logic [LOG_N_STREAMS-1:0]         grant;
    logic                             any_valid;
    logic [LOG_N_STREAMS-1:0]         cur_sel;
    logic                             pop;
    logic [WIDTH-1:0]                 head;
    logic [LOG_MAX_PACKET_LENGTH-1:0] hdr_len;
    logic                             is_hdr;
    logic                             oversize;

    round_robin_select #(
        .N     (N_STREAMS),
        .LOG_N (LOG_N_STREAMS)
    ) u_select (
        .req_i       (~bus.in_empty),
        .ptr_i       (start_ptr),
        .grant_o     (grant),
        .any_valid_o (any_valid)
    );

    // Pop is combinational off the buffer heads and forced low while in reset.
    always_comb begin
        cur_sel  = (state_q == IDLE) ? grant : sel_q;
        head     = bus.in_data[32'(cur_sel)*WIDTH +: WIDTH];
        hdr_len  = head[LOG_MAX_PACKET_LENGTH-1:0];
        is_hdr   = head[WIDTH-1];
        oversize = 32'(hdr_len) > MAX_PACKET_LENGTH;
        pop      = 1'b0;
        if (rst_n) begin
            pop = (state_q == IDLE) ? any_valid : !bus.in_empty[cur_sel];
        end
        bus.in_read = '0;
        if (pop) begin
            bus.in_read[cur_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            out_nd_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            out_nd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        sel_q <= cur_sel;
                        if (!is_hdr) begin
                            error_q <= 1'b1;
                        end else if (oversize) begin
                            error_q <= 1'b1;
                            count_q <= hdr_len;
                            state_q <= DROP;
                        end else begin
                            out_data_q <= head;
                            out_nd_q   <= 1'b1;
                            count_q    <= hdr_len;
                            if (hdr_len != '0) begin
                                state_q <= SEND;
                            end
                        end
                    end
                end
                SEND, DROP: begin
                    if (pop) begin
                        if (state_q == SEND) begin
                            out_data_q <= head;
                            out_nd_q   <= 1'b1;
                        end
                        count_q <= count_q - 1'b1;
                        if (count_q == LOG_MAX_PACKET_LENGTH'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MESSAGE_STREAM_ARBITER_FIXED_PRIORITY_EN
    assign start_ptr = '0;
`else
    logic [LOG_N_STREAMS-1:0] rr_ptr_q;
    logic [LOG_N_STREAMS-1:0] nxt_sel;
    logic                     pkt_done;

    // A packet ends on a zero-length header in IDLE or the last payload pop.
    assign nxt_sel  = LOG_N_STREAMS'(wrap_add(32'(cur_sel), 1, N_STREAMS));
    assign pkt_done = pop && ((state_q == IDLE) ? (is_hdr && !oversize && hdr_len == '0)
                                                : (count_q == LOG_MAX_PACKET_LENGTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (pkt_done) begin
            rr_ptr_q <= nxt_sel;
        end
    end

    assign start_ptr = rr_ptr_q;
`endif

    assign bus.out_data = out_data_q;
    assign bus.out_nd   = out_nd_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_message_stream_arbiter.sv
// Bench for message_stream_arbiter: modelled FWFT buffers, scoreboard of
// expected output words, a vector table plus hand-built multi-cycle sequences.
module tb_message_stream_arbiter;
    localparam int unsigned NS   = 3;
    localparam int unsigned LNS  = 2;
    localparam int unsigned W    = 32;
    localparam int unsigned MAXL = 8;
    localparam int unsigned LML  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    message_stream_arbiter_if #(.N_STREAMS(NS), .WIDTH(W)) bus ();

    message_stream_arbiter #(
        .N_STREAMS             (NS),
        .LOG_N_STREAMS         (LNS),
        .WIDTH                 (W),
        .MAX_PACKET_LENGTH     (MAXL),
        .LOG_MAX_PACKET_LENGTH (LML)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [W-1:0] sq [NS][$];
    logic [W-1:0] exp_q [$];
    logic [NS-1:0] rd_q;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_rd = -1;
    int first_nd = -1;
    int last_nd  = -1;
    int nd_cnt   = 0;

    typedef struct {
        int          stream;
        logic [31:0] hdr;
        int          npay;
        logic [31:0] pay_base;
        int          exp_fwd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Buffer model: pops registered at posedge are applied at the next negedge.
    always @(posedge clk) rd_q <= bus.in_read;

    always @(negedge clk) begin
        for (int i = 0; i < NS; i++)
            if (rd_q[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        #1;
        for (int i = 0; i < NS; i++) begin
            bus.in_empty[i] = (sq[i].size() == 0);
            bus.in_data[i*W +: W] = (sq[i].size() == 0) ? '0 : sq[i][0];
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        #2;
        if (rst_n) begin
            cyc++;
            if (bus.in_read != '0) begin
                check("in_read legal", 32'(((bus.in_read & bus.in_empty) == '0) && $onehot(bus.in_read)), 32'd1);
                if (first_rd < 0) first_rd = cyc;
            end
            if (bus.out_nd) begin
                if (first_nd < 0) first_nd = cyc;
                last_nd = cyc;
                nd_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected out_nd: got data %h, expected no output", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < NS; i++) sq[i].delete();
        exp_q.delete();
        #3;
        check("reset out_nd", 32'(bus.out_nd), 32'd0);
        check("reset out_data", bus.out_data, 32'd0);
        check("reset error", 32'(bus.error), 32'd0);
        check("reset in_read", 32'(bus.in_read), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        first_rd = -1; first_nd = -1; last_nd = -1; nd_cnt = 0;
    endtask

    task automatic push(input int s, input logic [31:0] w, input bit expect_out);
        sq[s].push_back(w);
        if (expect_out) exp_q.push_back(w);
    endtask

    task automatic wait_drain(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge clk);
            #3;
            done = (sq[0].size() == 0) && (sq[1].size() == 0) && (sq[2].size() == 0) && (exp_q.size() == 0);
        end
        if (!done) check("drain timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        #3;
    endtask

    initial begin
        logic [31:0] w;
        bit hit;
        tbl[0] = '{1, 32'h8000_0003, 3,  32'h0000_000A, 4, 1'b0};
        tbl[1] = '{0, 32'h8000_0000, 0,  32'h0000_0000, 1, 1'b0};
        tbl[2] = '{2, 32'h8000_0008, 8,  32'h8000_1000, 9, 1'b0};
        tbl[3] = '{1, 32'h8000_0009, 9,  32'h0000_2000, 0, 1'b1};
        tbl[4] = '{2, 32'h0000_0055, 0,  32'h0000_0000, 0, 1'b1};
        tbl[5] = '{0, 32'h8000_000F, 15, 32'h0000_3000, 0, 1'b1};

        for (int t = 0; t < 6; t++) begin
            reset_dut();
            @(negedge clk);
            push(tbl[t].stream, tbl[t].hdr, tbl[t].exp_fwd > 0);
            for (int k = 0; k < tbl[t].npay; k++)
                push(tbl[t].stream, tbl[t].pay_base + 32'(k), tbl[t].exp_fwd > 0);
            wait_drain(100);
            check($sformatf("vec%0d error", t), 32'(bus.error), 32'(tbl[t].exp_err));
            check($sformatf("vec%0d word count", t), 32'(nd_cnt), 32'(tbl[t].exp_fwd));
            if (tbl[t].exp_fwd > 0) begin
                check($sformatf("vec%0d latency", t), 32'(first_nd - first_rd), 32'd1);
                check($sformatf("vec%0d contiguous", t), 32'(last_nd - first_nd + 1), 32'(tbl[t].exp_fwd));
            end
        end

        // Fairness: two L=1 packets per stream, headers tagged with stream/packet
        reset_dut();
        @(negedge clk);
        for (int s = 0; s < NS; s++)
            for (int p = 0; p < 2; p++) begin
                sq[s].push_back(32'h8000_0001 | (32'(s) << 8) | (32'(p) << 12));
                sq[s].push_back(32'h5000_0000 | (32'(s) << 8) | 32'(p));
            end
`ifdef MESSAGE_STREAM_ARBITER_FIXED_PRIORITY_EN
        for (int s = 0; s < NS; s++)
            for (int p = 0; p < 2; p++) begin
`else
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NS; s++) begin
`endif
                exp_q.push_back(32'h8000_0001 | (32'(s) << 8) | (32'(p) << 12));
                exp_q.push_back(32'h5000_0000 | (32'(s) << 8) | 32'(p));
            end
        wait_drain(100);
        check("fair count", 32'(nd_cnt), 32'd12);
        check("fair no gap", 32'(last_nd - first_nd + 1), 32'd12);

        // Stall: stream 0 runs dry mid-packet while stream 2 waits
        reset_dut();
        @(negedge clk);
        push(0, 32'h8000_0002, 1'b1);
        push(0, 32'h0000_6001, 1'b1);
        for (int k = 0; k < 50 && sq[0].size() != 0; k++) begin
            @(negedge clk);
            #3;
        end
        check("stall reached", 32'(sq[0].size()), 32'd0);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                push(2, 32'h8000_0201, 1'b0);
                push(2, 32'h0000_6201, 1'b0);
            end
            @(negedge clk);
            #3;
            check("stall in_read", 32'(bus.in_read), 32'd0);
            check("stall out_nd", 32'(bus.out_nd), 32'd0);
        end
        @(negedge clk);
        push(0, 32'h0000_6002, 1'b1);
        exp_q.push_back(32'h8000_0201);
        exp_q.push_back(32'h0000_6201);
        wait_drain(100);
        check("stall error", 32'(bus.error), 32'd0);

        // Bad header followed by a valid packet on the same stream
        reset_dut();
        @(negedge clk);
        push(2, 32'h0000_0055, 1'b0);
        push(2, 32'h8000_0201, 1'b1);
        push(2, 32'h0000_7201, 1'b1);
        wait_drain(100);
        check("badhdr error", 32'(bus.error), 32'd1);
        check("badhdr count", 32'(nd_cnt), 32'd2);
        repeat (4) @(negedge clk);
        #3;
        check("badhdr error sticky", 32'(bus.error), 32'd1);

        // Oversize header: whole packet dropped, next streams served after it
        reset_dut();
        @(negedge clk);
        push(0, 32'h8000_000C, 1'b0);
        for (int k = 0; k < 12; k++) push(0, 32'h0000_9000 + 32'(k), 1'b0);
        push(1, 32'h8000_0101, 1'b1);
        push(1, 32'h0000_9101, 1'b1);
        push(2, 32'h8000_0201, 1'b1);
        push(2, 32'h0000_9201, 1'b1);
        wait_drain(100);
        check("oversize error", 32'(bus.error), 32'd1);
        check("oversize count", 32'(nd_cnt), 32'd4);

        // Reset mid-packet after moving the round-robin pointer off zero
        reset_dut();
        @(negedge clk);
        push(1, 32'h8000_0100, 1'b1);
        wait_drain(50);
        @(negedge clk);
        push(0, 32'h8000_0003, 1'b1);
        push(0, 32'h0000_8A01, 1'b1);
        push(0, 32'h0000_8A02, 1'b0);
        push(0, 32'h0000_8A03, 1'b0);
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(negedge clk);
            #3;
            hit = bus.out_nd && (bus.out_data == 32'h0000_8A01);
        end
        check("midpkt reached", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midpkt out_nd", 32'(bus.out_nd), 32'd0);
        check("midpkt in_read", 32'(bus.in_read), 32'd0);
        reset_dut();
        @(negedge clk);
        for (int s = 0; s < NS; s++) begin
            w = 32'h8000_0000 | (32'(s) << 8);
            push(s, w, 1'b1);
        end
        wait_drain(50);
        check("post-reset count", 32'(nd_cnt), 32'd3);
        check("post-reset error", 32'(bus.error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
